cmd_decoder_gen: RTL and testbench
==================================

Name: cmd_decoder_gen

Overview:
Parametrised successor command decoder between the host SPI slave and the flash memory controller. Latches one host frame, then decodes {CMD, ADDR, VAL}. It then executes one of: a register access, an ID reply, a memory address set, or a memory operation, and returns an optional reply frame to the SPI slave. Compared with the fixed decoder it adds a generic register file, a generic memory address width, bounded waits with a watchdog, explicit error replies and a dropped-frame indication.

Parameters:
- CMD_W, 4, opcode field width.
- ADDR_W, 4, address/selector field width.
- VAL_W, 8, value field width; also the register width.
- NUM_REGS, 4, register file depth (≤ 2**ADDR_W).
- MEM_ADDR_W, 24, flash address width; must be a multiple of VAL_W.
- REPLY_W, 48, reply/memory data width.
- TIMEOUT_CYC, 4096, watchdog limit in CLK cycles for any handshake wait.
- DEV_ID, 16'h7975, SEND_ID payload.

Ports:
- CLK  in  1  system clock.
- CMD_RST_N  in  1  asynchronous active-low reset.
- rx_valid  in  1  one-cycle pulse: new host frame.
- rx_frame  in  CMD_W+ADDR_W+VAL_W  {CMD, ADDR, VAL}, MSB first.
- rx_drop  out  1  pulse: frame arrived while not IDLE and was discarded.
- tx_trigger  out  1  reply request to SPI slave.
- tx_busy  in  1  SPI slave busy.
- tx_data  out  REPLY_W  reply payload, right-aligned.
- tx_len  out  3  byte-count code: 0 none, 1 one, 2 two, 6 six, 7 long.
- mem_cmd  out  8  flash opcode.
- mem_addr  out  MEM_ADDR_W  flash address.
- mem_trig  out  1  memory request.
- mem_busy  in  1  memory controller busy.
- mem_rdata  in  REPLY_W  memory result.
- err  out  1  sticky error flag; cleared by the next accepted frame.

Behaviour:
- Reset (async, CMD_RST_N=0): state IDLE; all outputs 0; tx_len=2; registers and mem_addr 0.
- States: IDLE, DECODE, EXEC, MEM_REQ, MEM_WAIT, TX_REQ, TX_WAIT.
- IDLE: on rx_valid, latch the fields, clear err, go to DECODE (1 cycle). An rx_valid in any other state gives rx_drop=1 for that cycle and the state is unchanged.
- DECODE → EXEC with the opcode classified. Opcodes:
  - 2 SET_REG
  - 3 GET_REG
  - 4 CLR_REGS
  - 6 SEND_ID
  - 7 MEM_ID (9F, 6 B)
  - 8 MEM_STREG (ADDR 0..3 → 05/07/AB/35, 1 B)
  - A MEM_WRITE (11, none)
  - B ADDR_SET
  - C MEM_READ (0B, long)
  - D MEM_ERASE (C7, none)
  - anything else is an error.
- SET_REG: reg[ADDR]<=VAL → IDLE. ADDR ≥ NUM_REGS is an error.
- GET_REG: tx_data={CMD,ADDR,reg[ADDR]}, tx_len=2 → TX_REQ.
- SEND_ID: tx_data=DEV_ID, tx_len=2 → TX_REQ.
- CLR_REGS: all registers 0 → IDLE.
- ADDR_SET: byte lane ADDR of mem_addr <= VAL → IDLE. A lane ≥ MEM_ADDR_W/VAL_W is an error.
- MEM_REQ: mem_trig=1 until mem_busy is seen high, then mem_trig=0 the next cycle → MEM_WAIT.
- MEM_WAIT: on mem_busy=0, latch mem_rdata into tx_data. If tx_len≠0 → TX_REQ, else → IDLE.
- TX_REQ: raise tx_trigger only when tx_busy=0. Hold it until tx_busy=1, then drop → TX_WAIT.
- TX_WAIT: tx_busy=0 → IDLE.
- Watchdog: a counter clears on entry to MEM_REQ, MEM_WAIT, TX_REQ or TX_WAIT. Reaching TIMEOUT_CYC−1 sets err, deasserts mem_trig/tx_trigger and goes to IDLE; no retry.
- Error reply: an error detected in EXEC sets err and sends tx_data={4'hF,4'hE,CMD,ADDR}, tx_len=2 via TX_REQ. A watchdog error sends no reply.
- mem_cmd and mem_trig are 0 outside MEM_REQ/MEM_WAIT. mem_addr is stable while mem_trig=1.
- Reset mid-operation aborts immediately; no partial register write.

Optional Feature:
- CMD_DEC_PARITY_EN defined: rx_frame gains 1 extra LSB, even parity over the whole frame.
- Bad parity: frame accepted, err=1, error reply code {4'hF,4'hD,CMD,ADDR}; no execution.
- Undefined: no parity bit, no check.

Decomposition:
- Package cmd_decoder_pkg:
  - state enum
  - opcode constants
  - tx_len codes (NO_BY, ONE_BY, STD_TWO_BY, SIX_BY, LONG)
  - flash opcode constants
  - error codes
- Sub-module cmd_watchdog: counter with clear/enable/expire, parameter TIMEOUT_CYC.

Test Plan:
- Frame 0x2155 then 0x3100 → reg[1]=0x55; tx_trigger once, tx_data=0x3155, tx_len=2, IDLE after tx_busy falls.
- Frames B012, B134, B256 then 0x7000, with mem_busy high for 10 cycles and mem_rdata=0x0120184D0180 → mem_addr=0x563412, mem_cmd=9F, tx_data=0x0120184D0180, tx_len=6.
- Frame 0xF000 → err=1, tx_data=0xFEF0, tx_len=2; the next valid frame clears err.
- Frame 0xD000 with mem_busy never rising → after TIMEOUT_CYC cycles mem_trig=0, err=1, IDLE, no tx_trigger.
- Second rx_valid during MEM_WAIT → rx_drop pulses once; the first operation completes unaffected.
- CMD_RST_N low mid-TX_REQ → tx_trigger=0 asynchronously, registers 0, state IDLE.

Source files
------------

// File: rtl/cmd_decoder_pkg.sv
// Shared types and constants for the host command decoder.
//   - FSM state encoding and decoded opcode classes
//   - host opcodes, reply byte-count codes, flash opcodes, error codes
//   - streg_opcode(): maps a status-register selector to its flash opcode
package cmd_decoder_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DECODE,
      ST_EXEC,
      ST_MEM_REQ,
      ST_MEM_WAIT,
      ST_TX_REQ,
      ST_TX_WAIT
   } state_e;

   typedef enum logic [2:0] {
      OPC_SET_REG,
      OPC_GET_REG,
      OPC_CLR_REGS,
      OPC_SEND_ID,
      OPC_ADDR_SET,
      OPC_MEM,
      OPC_ERR
   } opclass_e;

   // host opcodes
   localparam logic [3:0] OP_SET_REG   = 4'h2;
   localparam logic [3:0] OP_GET_REG   = 4'h3;
   localparam logic [3:0] OP_CLR_REGS  = 4'h4;
   localparam logic [3:0] OP_SEND_ID   = 4'h6;
   localparam logic [3:0] OP_MEM_ID    = 4'h7;
   localparam logic [3:0] OP_MEM_STREG = 4'h8;
   localparam logic [3:0] OP_MEM_WRITE = 4'hA;
   localparam logic [3:0] OP_ADDR_SET  = 4'hB;
   localparam logic [3:0] OP_MEM_READ  = 4'hC;
   localparam logic [3:0] OP_MEM_ERASE = 4'hD;

   // reply byte-count codes
   localparam logic [2:0] NO_BY      = 3'd0;
   localparam logic [2:0] ONE_BY     = 3'd1;
   localparam logic [2:0] STD_TWO_BY = 3'd2;
   localparam logic [2:0] SIX_BY     = 3'd6;
   localparam logic [2:0] LONG       = 3'd7;

   // flash opcodes
   localparam logic [7:0] FL_READ_ID  = 8'h9F;
   localparam logic [7:0] FL_STREG0   = 8'h05;
   localparam logic [7:0] FL_STREG1   = 8'h07;
   localparam logic [7:0] FL_STREG2   = 8'hAB;
   localparam logic [7:0] FL_STREG3   = 8'h35;
   localparam logic [7:0] FL_WRITE    = 8'h11;
   localparam logic [7:0] FL_READ     = 8'h0B;
   localparam logic [7:0] FL_ERASE    = 8'hC7;

   // error reply: {ERR_PREFIX, code, CMD, ADDR}
   localparam logic [3:0] ERR_PREFIX = 4'hF;
   localparam logic [3:0] ERR_OPCODE = 4'hE;
   localparam logic [3:0] ERR_PARITY = 4'hD;

   function automatic logic [7:0] streg_opcode(input logic [1:0] sel);
      logic [7:0] op;
      case (sel)
         2'd0:    op = FL_STREG0;
         2'd1:    op = FL_STREG1;
         2'd2:    op = FL_STREG2;
         default: op = FL_STREG3;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/cmd_decoder_gen_watchdog.sv
// Handshake watchdog for the command decoder.
// Down-counter loaded with TIMEOUT_CYC-1 on clr_i, decremented while en_i;
// expire_o flags the TIMEOUT_CYC-th enabled cycle after a clear.
//   clk_i, rst_n_i : clock, async active-low reset
//   clr_i          : reload (entry into a wait state)
//   en_i           : counting enabled (currently in a wait state)
//   expire_o       : terminal count reached while enabled
module cmd_watchdog #(
   parameter int TIMEOUT_CYC = 4096
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic clr_i,
   input  logic en_i,
   output logic expire_o
);

   localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CNT_W-1:0] LOAD = CNT_W'(TIMEOUT_CYC - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = LOAD;
      end else if (en_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cnt_q <= LOAD;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/cmd_decoder_gen.sv
// Host command decoder between the SPI slave and the flash controller.
// Latches one {CMD, ADDR, VAL} frame, executes a register access, ID reply,
// flash address update or flash operation, and optionally returns a reply.
// Optional build macro: CMD_DEC_PARITY_EN (adds an even-parity LSB to rx_frame).
// Ports:
//   CLK, CMD_RST_N          clock, async active-low reset
//   rx_valid, rx_frame      host frame strobe and payload
//   rx_drop                 frame discarded because the decoder was busy
//   tx_trigger, tx_busy     reply handshake with the SPI slave
//   tx_data, tx_len         reply payload (right-aligned) and byte-count code
//   mem_cmd, mem_addr       flash opcode and address
//   mem_trig, mem_busy      flash request handshake
//   mem_rdata               flash result
//   err                     sticky error, cleared by the next accepted frame
//
// state       | meaning
// ------------+---------------------------------------------------------
// ST_IDLE     | waiting for a host frame
// ST_DECODE   | classify opcode, stage flash opcode and reply length
// ST_EXEC     | perform register/address action or build reply
// ST_MEM_REQ  | mem_trig high until the controller reports busy
// ST_MEM_WAIT | wait for the controller to finish, capture its data
// ST_TX_REQ   | raise tx_trigger once the SPI slave is free, hold to busy
// ST_TX_WAIT  | wait for the SPI slave to finish sending
module cmd_decoder_gen
   import cmd_decoder_pkg::*;
#(
   parameter int          CMD_W       = 4,
   parameter int          ADDR_W      = 4,
   parameter int          VAL_W       = 8,
   parameter int          NUM_REGS    = 4,
   parameter int          MEM_ADDR_W  = 24,
   parameter int          REPLY_W     = 48,
   parameter int          TIMEOUT_CYC = 4096,
   parameter logic [15:0] DEV_ID      = 16'h7975
) (
   input  logic                  CLK,
   input  logic                  CMD_RST_N,
   input  logic                  rx_valid,
`ifdef CMD_DEC_PARITY_EN
   input  logic [CMD_W+ADDR_W+VAL_W:0]   rx_frame,
`else
   input  logic [CMD_W+ADDR_W+VAL_W-1:0] rx_frame,
`endif
   output logic                  rx_drop,
   output logic                  tx_trigger,
   input  logic                  tx_busy,
   output logic [REPLY_W-1:0]    tx_data,
   output logic [2:0]            tx_len,
   output logic [7:0]            mem_cmd,
   output logic [MEM_ADDR_W-1:0] mem_addr,
   output logic                  mem_trig,
   input  logic                  mem_busy,
   input  logic [REPLY_W-1:0]    mem_rdata,
   output logic                  err
);

`ifdef CMD_DEC_PARITY_EN
   localparam int PAR_W = 1;
`else
   localparam int PAR_W = 0;
`endif
   localparam int FRAME_W = CMD_W + ADDR_W + VAL_W + PAR_W;
   localparam int LANES   = MEM_ADDR_W / VAL_W;

   state_e                state_q, state_d;
   opclass_e              opc_q, opc_d;
   logic [CMD_W-1:0]      cmd_q, cmd_d;
   logic [ADDR_W-1:0]     addr_q, addr_d;
   logic [VAL_W-1:0]      val_q, val_d;
   logic                  par_bad_q, par_bad_d;
   logic [3:0]            ecode_q, ecode_d;
   logic [REPLY_W-1:0]    tx_data_q, tx_data_d;
   logic [2:0]            tx_len_q, tx_len_d;
   logic [7:0]            mem_cmd_q, mem_cmd_d;
   logic [MEM_ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [VAL_W-1:0]      regs_q [NUM_REGS];
   logic [VAL_W-1:0]      regs_d [NUM_REGS];
   logic                  err_q, err_d;
   logic                  tx_trig_q, tx_trig_d;

   logic [VAL_W-1:0]      reg_rd;
   logic                  frame_par_bad;
   logic                  wd_clr, wd_en, wd_expire;

`ifdef CMD_DEC_PARITY_EN
   // even parity over the full frame including the parity bit
   assign frame_par_bad = ^rx_frame;
`else
   assign frame_par_bad = 1'b0;
`endif

   always_comb begin
      reg_rd = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (addr_q == ADDR_W'(i)) reg_rd = regs_q[i];
      end
   end

   // Watchdog restarts on every entry into a handshake wait state,
   // including wait-to-wait transitions.
   always_comb begin
      wd_en  = state_q inside {ST_MEM_REQ, ST_MEM_WAIT, ST_TX_REQ, ST_TX_WAIT};
      wd_clr = (state_d != state_q) &&
               (state_d inside {ST_MEM_REQ, ST_MEM_WAIT, ST_TX_REQ, ST_TX_WAIT});
   end

   cmd_watchdog #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_watchdog (
      .clk_i    (CLK),
      .rst_n_i  (CMD_RST_N),
      .clr_i    (wd_clr),
      .en_i     (wd_en),
      .expire_o (wd_expire)
   );

   always_comb begin
      state_d    = state_q;
      opc_d      = opc_q;
      cmd_d      = cmd_q;
      addr_d     = addr_q;
      val_d      = val_q;
      par_bad_d  = par_bad_q;
      ecode_d    = ecode_q;
      tx_data_d  = tx_data_q;
      tx_len_d   = tx_len_q;
      mem_cmd_d  = mem_cmd_q;
      mem_addr_d = mem_addr_q;
      regs_d     = regs_q;
      err_d      = err_q;
      tx_trig_d  = tx_trig_q;

      case (state_q)
         ST_IDLE: begin
            if (rx_valid) begin
               cmd_d     = rx_frame[FRAME_W-1 -: CMD_W];
               addr_d    = rx_frame[FRAME_W-1-CMD_W -: ADDR_W];
               val_d     = rx_frame[PAR_W +: VAL_W];
               par_bad_d = frame_par_bad;
               err_d     = 1'b0;
               state_d   = ST_DECODE;
            end
         end

         ST_DECODE: begin
            opc_d   = OPC_ERR;
            ecode_d = ERR_OPCODE;
            case (cmd_q)
               CMD_W'(OP_SET_REG):
                  if (int'(addr_q) < NUM_REGS) opc_d = OPC_SET_REG;
               CMD_W'(OP_GET_REG):
                  if (int'(addr_q) < NUM_REGS) opc_d = OPC_GET_REG;
               CMD_W'(OP_CLR_REGS):  opc_d = OPC_CLR_REGS;
               CMD_W'(OP_SEND_ID):   opc_d = OPC_SEND_ID;
               CMD_W'(OP_ADDR_SET):
                  if (int'(addr_q) < LANES) opc_d = OPC_ADDR_SET;
               CMD_W'(OP_MEM_ID): begin
                  opc_d     = OPC_MEM;
                  mem_cmd_d = FL_READ_ID;
                  tx_len_d  = SIX_BY;
               end
               CMD_W'(OP_MEM_STREG): begin
                  if (int'(addr_q) < 4) begin
                     opc_d     = OPC_MEM;
                     mem_cmd_d = streg_opcode(addr_q[1:0]);
                     tx_len_d  = ONE_BY;
                  end
               end
               CMD_W'(OP_MEM_WRITE): begin
                  opc_d     = OPC_MEM;
                  mem_cmd_d = FL_WRITE;
                  tx_len_d  = NO_BY;
               end
               CMD_W'(OP_MEM_READ): begin
                  opc_d     = OPC_MEM;
                  mem_cmd_d = FL_READ;
                  tx_len_d  = LONG;
               end
               CMD_W'(OP_MEM_ERASE): begin
                  opc_d     = OPC_MEM;
                  mem_cmd_d = FL_ERASE;
                  tx_len_d  = NO_BY;
               end
               default: opc_d = OPC_ERR;
            endcase
            // a corrupted frame is never executed, whatever its opcode
            if (par_bad_q) begin
               opc_d   = OPC_ERR;
               ecode_d = ERR_PARITY;
            end
            state_d = ST_EXEC;
         end

         ST_EXEC: begin
            state_d = ST_IDLE;
            case (opc_q)
               OPC_SET_REG: begin
                  for (int i = 0; i < NUM_REGS; i++) begin
                     if (addr_q == ADDR_W'(i)) regs_d[i] = val_q;
                  end
               end
               OPC_GET_REG: begin
                  tx_data_d = REPLY_W'({cmd_q, addr_q, reg_rd});
                  tx_len_d  = STD_TWO_BY;
                  state_d   = ST_TX_REQ;
               end
               OPC_CLR_REGS: begin
                  for (int i = 0; i < NUM_REGS; i++) regs_d[i] = '0;
               end
               OPC_SEND_ID: begin
                  tx_data_d = REPLY_W'(DEV_ID);
                  tx_len_d  = STD_TWO_BY;
                  state_d   = ST_TX_REQ;
               end
               OPC_ADDR_SET: begin
                  for (int l = 0; l < LANES; l++) begin
                     if (addr_q == ADDR_W'(l)) mem_addr_d[l*VAL_W +: VAL_W] = val_q;
                  end
               end
               OPC_MEM: state_d = ST_MEM_REQ;
               default: begin
                  err_d     = 1'b1;
                  tx_data_d = REPLY_W'({ERR_PREFIX, ecode_q, cmd_q, addr_q});
                  tx_len_d  = STD_TWO_BY;
                  state_d   = ST_TX_REQ;
               end
            endcase
         end

         ST_MEM_REQ: begin
            if (wd_expire) begin
               err_d   = 1'b1;
               state_d = ST_IDLE;
            end else if (mem_busy) begin
               state_d = ST_MEM_WAIT;
            end
         end

         ST_MEM_WAIT: begin
            if (wd_expire) begin
               err_d   = 1'b1;
               state_d = ST_IDLE;
            end else if (!mem_busy) begin
               tx_data_d = mem_rdata;
               state_d   = (tx_len_q != NO_BY) ? ST_TX_REQ : ST_IDLE;
            end
         end

         ST_TX_REQ: begin
            if (wd_expire) begin
               err_d     = 1'b1;
               tx_trig_d = 1'b0;
               state_d   = ST_IDLE;
            end else if (!tx_trig_q) begin
               // only start a reply once the previous transfer has ended
               if (!tx_busy) tx_trig_d = 1'b1;
            end else if (tx_busy) begin
               tx_trig_d = 1'b0;
               state_d   = ST_TX_WAIT;
            end
         end

         ST_TX_WAIT: begin
            if (wd_expire) begin
               err_d   = 1'b1;
               state_d = ST_IDLE;
            end else if (!tx_busy) begin
               state_d = ST_IDLE;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge CMD_RST_N) begin
      if (!CMD_RST_N) begin
         state_q    <= ST_IDLE;
         opc_q      <= OPC_ERR;
         cmd_q      <= '0;
         addr_q     <= '0;
         val_q      <= '0;
         par_bad_q  <= 1'b0;
         ecode_q    <= ERR_OPCODE;
         tx_data_q  <= '0;
         tx_len_q   <= STD_TWO_BY;
         mem_cmd_q  <= '0;
         mem_addr_q <= '0;
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
         err_q      <= 1'b0;
         tx_trig_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         opc_q      <= opc_d;
         cmd_q      <= cmd_d;
         addr_q     <= addr_d;
         val_q      <= val_d;
         par_bad_q  <= par_bad_d;
         ecode_q    <= ecode_d;
         tx_data_q  <= tx_data_d;
         tx_len_q   <= tx_len_d;
         mem_cmd_q  <= mem_cmd_d;
         mem_addr_q <= mem_addr_d;
         regs_q     <= regs_d;
         err_q      <= err_d;
         tx_trig_q  <= tx_trig_d;
      end
   end

   assign rx_drop    = rx_valid && (state_q != ST_IDLE);
   assign tx_trigger = tx_trig_q;
   assign tx_data    = tx_data_q;
   assign tx_len     = tx_len_q;
   assign mem_trig   = (state_q == ST_MEM_REQ);
   assign mem_cmd    = (state_q == ST_MEM_REQ || state_q == ST_MEM_WAIT) ? mem_cmd_q : 8'h00;
   assign mem_addr   = mem_addr_q;
   assign err        = err_q;

endmodule

// File: tb/tb_cmd_decoder_gen.sv
module tb_cmd_decoder_gen;
   import cmd_decoder_pkg::*;

   localparam int TO = 64;
   localparam int FW = 16;

   logic        CLK = 1'b0;
   logic        CMD_RST_N = 1'b0;
   logic        rx_valid = 1'b0;
   logic [FW-1:0] rx_frame = '0;
   logic        rx_drop, tx_trigger, tx_busy, mem_trig, mem_busy, err;
   logic [47:0] tx_data, mem_rdata;
   logic [2:0]  tx_len;
   logic [7:0]  mem_cmd;
   logic [23:0] mem_addr;

   typedef struct packed {
      logic [47:0] data;
      logic [2:0]  len;
   } rpl_t;

   rpl_t exp_q[$];

   int vectors = 0;
   int miscompares = 0;
   int trig_cnt = 0;
   int drop_cnt = 0;
   logic trig_prev = 1'b0;

   bit spi_en = 1'b0;
   bit mem_en = 1'b0;
   int mem_lat = 10;
   logic [47:0] mem_val = '0;

   always #5 CLK = ~CLK;

   cmd_decoder_gen #(.TIMEOUT_CYC(TO)) dut (
      .CLK        (CLK),
      .CMD_RST_N  (CMD_RST_N),
      .rx_valid   (rx_valid),
      .rx_frame   (rx_frame),
      .rx_drop    (rx_drop),
      .tx_trigger (tx_trigger),
      .tx_busy    (tx_busy),
      .tx_data    (tx_data),
      .tx_len     (tx_len),
      .mem_cmd    (mem_cmd),
      .mem_addr   (mem_addr),
      .mem_trig   (mem_trig),
      .mem_busy   (mem_busy),
      .mem_rdata  (mem_rdata),
      .err        (err)
   );

   always @(negedge CLK) begin
      if (tx_trigger && !trig_prev) trig_cnt <= trig_cnt + 1;
      if (rx_drop) drop_cnt <= drop_cnt + 1;
      trig_prev <= tx_trigger;
   end

   // SPI slave model
   initial begin
      tx_busy = 1'b0;
      forever begin
         @(negedge CLK);
         if (spi_en && tx_trigger) begin
            @(posedge CLK); #1 tx_busy = 1'b1;
            repeat (3) @(posedge CLK);
            #1 tx_busy = 1'b0;
         end
      end
   end

   // flash controller model
   initial begin
      mem_busy  = 1'b0;
      mem_rdata = '0;
      forever begin
         @(negedge CLK);
         if (mem_en && mem_trig) begin
            @(posedge CLK); #1 mem_busy = 1'b1;
            repeat (mem_lat) @(posedge CLK);
            #1 mem_rdata = mem_val;
            mem_busy = 1'b0;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   task automatic send_frame(input logic [FW-1:0] f);
      @(posedge CLK); #1;
      rx_valid = 1'b1;
      rx_frame = f;
      @(posedge CLK); #1;
      rx_valid = 1'b0;
   endtask

   task automatic wait_tx(output bit ok);
      ok = 1'b0;
      for (int c = 0; c < 300; c++) begin
         @(negedge CLK);
         if (tx_trigger) begin ok = 1'b1; break; end
      end
   endtask

   task automatic wait_idle(output bit ok);
      ok = 1'b0;
      for (int c = 0; c < 300; c++) begin
         @(negedge CLK);
         if (dut.state_q == ST_IDLE) begin ok = 1'b1; break; end
      end
   endtask

   task automatic wait_mem_trig(output bit ok);
      ok = 1'b0;
      for (int c = 0; c < 50; c++) begin
         @(negedge CLK);
         if (mem_trig) begin ok = 1'b1; break; end
      end
   endtask

   task automatic wait_mem_busy(output bit ok);
      ok = 1'b0;
      for (int c = 0; c < 50; c++) begin
         @(negedge CLK);
         if (mem_busy) begin ok = 1'b1; break; end
      end
   endtask

   // push expected reply, send frame, pop and compare on tx_trigger
   task automatic reply_check(input logic [FW-1:0] f, input logic [47:0] d,
                              input logic [2:0] l, input string name);
      rpl_t e;
      bit ok;
      exp_q.push_back(rpl_t'({d, l}));
      send_frame(f);
      wait_tx(ok);
      e = exp_q.pop_front();
      vectors++;
      if (!ok || tx_data !== e.data) begin
         miscompares++;
         $display("FAIL %s_data: trig=%0b got %h want %h", name, ok, tx_data, e.data);
      end
      vectors++;
      if (tx_len !== e.len) begin
         miscompares++;
         $display("FAIL %s_len: got %0d want %0d", name, tx_len, e.len);
      end
      wait_idle(ok);
   endtask

   task automatic test_reset();
      repeat (3) @(negedge CLK);
      vectors++;
      if ({tx_trigger, mem_trig, rx_drop, err} !== 4'b0000) begin
         miscompares++;
         $display("FAIL reset_flags: got %b want 0000", {tx_trigger, mem_trig, rx_drop, err});
      end
      vectors++;
      if (tx_len !== 3'd2) begin
         miscompares++;
         $display("FAIL reset_tx_len: got %0d want 2", tx_len);
      end
      vectors++;
      if (tx_data !== 48'h0 || mem_addr !== 24'h0 || mem_cmd !== 8'h0) begin
         miscompares++;
         $display("FAIL reset_data: got %h/%h/%h want 0", tx_data, mem_addr, mem_cmd);
      end
      vectors++;
      if (dut.state_q !== ST_IDLE) begin
         miscompares++;
         $display("FAIL reset_state: got %0d want %0d", dut.state_q, ST_IDLE);
      end
      #1 CMD_RST_N = 1'b1;
   endtask

   task automatic test_reg_access();
      bit ok;
      int t0;
      spi_en = 1'b1;
      send_frame(16'h2155);
      wait_idle(ok);
      t0 = trig_cnt;
      reply_check(16'h3100, 48'h3155, 3'd2, "get_reg1");
      vectors++;
      if (!ok && dut.state_q !== ST_IDLE) begin
         miscompares++;
         $display("FAIL get_reg1_idle: got %0d want %0d", dut.state_q, ST_IDLE);
      end
      vectors++;
      if (trig_cnt - t0 != 1) begin
         miscompares++;
         $display("FAIL get_reg1_trig_count: got %0d want 1", trig_cnt - t0);
      end
      vectors++;
      if (err !== 1'b0) begin
         miscompares++;
         $display("FAIL get_reg1_err: got %b want 0", err);
      end
   endtask

   task automatic test_mem_id();
      bit ok;
      send_frame(16'hB012); wait_idle(ok);
      send_frame(16'hB134); wait_idle(ok);
      send_frame(16'hB256); wait_idle(ok);
      vectors++;
      if (mem_addr !== 24'h563412) begin
         miscompares++;
         $display("FAIL addr_set: got %h want 563412", mem_addr);
      end
      mem_en  = 1'b1;
      mem_lat = 10;
      mem_val = 48'h0120184D0180;
      fork
         reply_check(16'h7000, 48'h0120184D0180, 3'd6, "mem_id");
         begin
            wait_mem_trig(ok);
            vectors++;
            if (!ok || mem_cmd !== 8'h9F) begin
               miscompares++;
               $display("FAIL mem_id_cmd: trig=%0b got %h want 9f", ok, mem_cmd);
            end
            vectors++;
            if (mem_addr !== 24'h563412) begin
               miscompares++;
               $display("FAIL mem_id_addr: got %h want 563412", mem_addr);
            end
         end
      join
      vectors++;
      if (mem_cmd !== 8'h00 || mem_trig !== 1'b0) begin
         miscompares++;
         $display("FAIL mem_idle_outputs: got cmd %h trig %b want 00/0", mem_cmd, mem_trig);
      end
   endtask

   task automatic test_error();
      reply_check(16'hF000, 48'hFEF0, 3'd2, "bad_opcode");
      vectors++;
      if (err !== 1'b1) begin
         miscompares++;
         $display("FAIL bad_opcode_err: got %b want 1", err);
      end
      fork
         reply_check(16'h6000, 48'h7975, 3'd2, "send_id");
         begin
            repeat (3) @(negedge CLK);
            vectors++;
            if (err !== 1'b0) begin
               miscompares++;
               $display("FAIL err_clear: got %b want 0", err);
            end
         end
      join
   endtask

   task automatic test_boundaries();
      bit ok;
      reply_check(16'h2433, 48'hFE24, 3'd2, "set_reg_oob");
      reply_check(16'hB3AA, 48'hFEB3, 3'd2, "addr_lane_oob");
      vectors++;
      if (mem_addr !== 24'h563412) begin
         miscompares++;
         $display("FAIL addr_lane_oob_keep: got %h want 563412", mem_addr);
      end
      send_frame(16'h23A5); wait_idle(ok);
      reply_check(16'h3300, 48'h33A5, 3'd2, "get_reg_last");
      send_frame(16'h4000); wait_idle(ok);
      reply_check(16'h3300, 48'h3300, 3'd2, "get_after_clr");
      mem_val = 48'h00000000005A;
      fork
         reply_check(16'h8200, 48'h5A, 3'd1, "streg2");
         begin
            wait_mem_trig(ok);
            vectors++;
            if (!ok || mem_cmd !== 8'hAB) begin
               miscompares++;
               $display("FAIL streg2_cmd: trig=%0b got %h want ab", ok, mem_cmd);
            end
         end
      join
      reply_check(16'h8400, 48'hFE84, 3'd2, "streg_oob");
   endtask

   task automatic test_drop();
      bit ok;
      int t0;
      t0 = drop_cnt;
      mem_val = 48'h0000000000C3;
      fork
         reply_check(16'h8000, 48'hC3, 3'd1, "drop_streg0");
         begin
            wait_mem_busy(ok);
            repeat (2) @(negedge CLK);
            vectors++;
            if (!ok || mem_cmd !== 8'h05) begin
               miscompares++;
               $display("FAIL drop_mem_cmd: busy=%0b got %h want 05", ok, mem_cmd);
            end
            @(posedge CLK); #1;
            rx_valid = 1'b1;
            rx_frame = 16'h2177;
            @(negedge CLK);
            vectors++;
            if (rx_drop !== 1'b1) begin
               miscompares++;
               $display("FAIL drop_pulse: got %b want 1", rx_drop);
            end
            @(posedge CLK); #1;
            rx_valid = 1'b0;
            @(negedge CLK);
            vectors++;
            if (rx_drop !== 1'b0) begin
               miscompares++;
               $display("FAIL drop_release: got %b want 0", rx_drop);
            end
         end
      join
      vectors++;
      if (drop_cnt - t0 != 1) begin
         miscompares++;
         $display("FAIL drop_count: got %0d want 1", drop_cnt - t0);
      end
      reply_check(16'h3100, 48'h3100, 3'd2, "drop_not_exec");
   endtask

   task automatic test_timeout();
      bit ok;
      int t0;
      int n;
      mem_en = 1'b0;
      t0 = trig_cnt;
      send_frame(16'hD000);
      wait_mem_trig(ok);
      n = 0;
      while (mem_trig && n < TO + 20) begin
         n++;
         @(negedge CLK);
      end
      vectors++;
      if (!ok || n != TO) begin
         miscompares++;
         $display("FAIL timeout_cycles: trig=%0b got %0d want %0d", ok, n, TO);
      end
      vectors++;
      if (err !== 1'b1) begin
         miscompares++;
         $display("FAIL timeout_err: got %b want 1", err);
      end
      vectors++;
      if (dut.state_q !== ST_IDLE || mem_cmd !== 8'h00) begin
         miscompares++;
         $display("FAIL timeout_idle: got state %0d cmd %h want %0d/00", dut.state_q, mem_cmd, ST_IDLE);
      end
      repeat (10) @(negedge CLK);
      vectors++;
      if (trig_cnt != t0) begin
         miscompares++;
         $display("FAIL timeout_no_reply: got %0d triggers want 0", trig_cnt - t0);
      end
      mem_en = 1'b1;
   endtask

   task automatic test_reset_mid_tx();
      bit ok;
      send_frame(16'h2199); wait_idle(ok);
      spi_en = 1'b0;
      send_frame(16'h3100);
      wait_tx(ok);
      vectors++;
      if (!ok || tx_data !== 48'h3199) begin
         miscompares++;
         $display("FAIL pre_reset_reply: trig=%0b got %h want 3199", ok, tx_data);
      end
      #2 CMD_RST_N = 1'b0;
      #1;
      vectors++;
      if (tx_trigger !== 1'b0) begin
         miscompares++;
         $display("FAIL async_reset_trig: got %b want 0", tx_trigger);
      end
      vectors++;
      if (dut.state_q !== ST_IDLE || tx_len !== 3'd2 || mem_addr !== 24'h0) begin
         miscompares++;
         $display("FAIL async_reset_state: got %0d/%0d/%h want %0d/2/0", dut.state_q, tx_len, mem_addr, ST_IDLE);
      end
      @(negedge CLK);
      CMD_RST_N = 1'b1;
      spi_en = 1'b1;
      reply_check(16'h3100, 48'h3100, 3'd2, "post_reset_reg");
   endtask

   initial begin
      test_reset();
      test_reg_access();
      test_mem_id();
      test_error();
      test_boundaries();
      test_drop();
      test_timeout();
      test_reset_mid_tx();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
